// File: rtl/my_pkg.sv
// Shared types and helpers for the instruction fetch unit and its cache.
package my_pkg;

  typedef enum logic [1:0] {
    PC_NEXT       = 2'd0,
    PC_BRANCH_ALU = 2'd1,
    PC_JUMP       = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    LAST   = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PcStep = 32'd4;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc_in);
    return pc_in + PcStep;
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache storage: valid bits, tags and data words.
// One write port shared by data and tag/valid; reads are asynchronous.
module icache_dm #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINES      = 16,
  parameter int unsigned OFF_W      = 2,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             we_i,
  input  logic             fill_i,
  input  logic [IDX_W-1:0] wr_line_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i,
  input  logic [IDX_W-1:0] rd_line_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*LINE_WORDS];

  // Flush wins over a same-edge fill so a refill finishing under flush is discarded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (we_i && fill_i) begin
      valid_q[wr_line_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_q[{wr_line_i, wr_off_i}] <= wr_data_i;
      if (fill_i) begin
        tag_q[wr_line_i] <= wr_tag_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_line_i];
  assign rd_tag_o   = tag_q[rd_line_i];
  assign rd_data_o  = data_q[{rd_line_i, rd_off_i}];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC sequencing, direct-mapped I-cache lookup and
// line refill from a 1-cycle-latency SRAM, plus a program-load bypass port.
module ifetch_unit
  import my_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINES      = 16,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              EN,
  input  pc_sel_e           pc_sel,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       jump_target,
  input  logic              id_ready,
  input  logic              flush_icache,
  input  logic              load_ctrl,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              imem_csb,
  output logic              imem_web,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  input  logic [31:0]       imem_dout,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_link,
  output logic              busy
);

  localparam int unsigned OffW  = $clog2(LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(LINES);
  localparam int unsigned TagW  = ADDR_W - OffW - IdxW;
  localparam int unsigned LineW = ADDR_W - OffW;

  fetch_state_e     state_q;
  logic [31:0]      pc_q, pc_d;
  logic [OffW-1:0]  cnt_q;
  logic [LineW-1:0] fill_q;
  logic             flush_pend_q;
  logic             load_q;

  logic [ADDR_W-1:0] word_idx;
  logic [OffW-1:0]   pc_off;
  logic [IdxW-1:0]   pc_line;
  logic [TagW-1:0]   pc_tag;

  logic            rd_valid;
  logic [TagW-1:0] rd_tag;
  logic [31:0]     rd_data;

  logic            active, lookup, hit, miss;
  logic            cache_we, cache_fill, cache_flush, flush_now;
  logic [OffW-1:0] wr_off;

  assign word_idx = pc_q[ADDR_W+1:2];
  assign pc_off   = word_idx[OffW-1:0];
  assign pc_line  = word_idx[OffW +: IdxW];
  assign pc_tag   = word_idx[ADDR_W-1 -: TagW];

  assign active      = EN && !load_ctrl;
  assign lookup      = active && (state_q == IDLE) && (pc_sel == PC_NEXT);
  assign hit         = rd_valid && (rd_tag == pc_tag);
  assign instr_valid = lookup && hit;
  assign miss        = lookup && !hit;
  assign instr       = rd_data;

  assign pc      = pc_q;
  assign pc_link = pc_plus4(pc_q);
  assign busy    = (state_q != IDLE);

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_BRANCH_ALU: pc_d = branch_target;
      PC_JUMP:       pc_d = jump_target;
      default: begin
        if (instr_valid && id_ready) begin
          pc_d = pc_plus4(pc_q);
        end
      end
    endcase
  end

  // Word k is issued while cnt_q == k and lands in the cache one cycle later.
  always_comb begin
    cache_we   = 1'b0;
    cache_fill = 1'b0;
    wr_off     = cnt_q - 1'b1;
    if (active) begin
      if (state_q == REFILL) begin
        cache_we = (cnt_q != '0);
      end else if (state_q == LAST) begin
        cache_we   = 1'b1;
        cache_fill = 1'b1;
        wr_off     = '1;
      end
    end
  end

  assign flush_now   = flush_icache || flush_pend_q;
  assign cache_flush = EN && ((load_q && !load_ctrl) ||
                              (!load_ctrl && (((state_q == IDLE) && flush_icache) ||
                                              ((state_q == LAST) && flush_now))));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      load_q       <= 1'b0;
    end else if (EN) begin
      load_q <= load_ctrl;
      if (load_ctrl) begin
        // Program load owns the SRAM: drop any refill without validating it.
        state_q      <= IDLE;
        cnt_q        <= '0;
        flush_pend_q <= 1'b0;
      end else begin
        pc_q <= pc_d;
        unique case (state_q)
          IDLE: begin
            if (miss) begin
              state_q <= REFILL;
              cnt_q   <= '0;
              fill_q  <= word_idx[ADDR_W-1:OffW];
            end
          end
          REFILL: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
              state_q <= LAST;
            end
            if (flush_icache) begin
              flush_pend_q <= 1'b1;
            end
          end
          LAST: begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    imem_csb  = 1'b1;
    imem_web  = 1'b1;
    imem_addr = '0;
    imem_din  = '0;
    if (RSTn && EN) begin
      if (load_ctrl) begin
        imem_csb  = 1'b0;
        imem_web  = 1'b0;
        imem_addr = load_addr;
        imem_din  = load_data;
      end else if (state_q == REFILL) begin
        imem_csb  = 1'b0;
        imem_addr = {fill_q, cnt_q};
      end
    end
  end

  icache_dm #(
    .LINE_WORDS(LINE_WORDS),
    .LINES     (LINES),
    .OFF_W     (OffW),
    .IDX_W     (IdxW),
    .TAG_W     (TagW)
  ) u_cache (
    .clk_i     (CLK),
    .rst_ni    (RSTn),
    .flush_i   (cache_flush),
    .we_i      (cache_we),
    .fill_i    (cache_fill),
    .wr_line_i (fill_q[IdxW-1:0]),
    .wr_off_i  (wr_off),
    .wr_tag_i  (fill_q[LineW-1:IdxW]),
    .wr_data_i (imem_dout),
    .rd_line_i (pc_line),
    .rd_off_i  (pc_off),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data)
  );

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- ADDR_W, 10, instruction-memory word-address width.
- LINE_WORDS, 4, words per cache line (power of 2, >=2).
- LINES, 16, cache lines (power of 2).
- RESET_PC, 32'h0, PC value after reset.

REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- CLK, in, 1, single clock.
- RSTn, in, 1, asynchronous active-low reset.
- EN, in, 1, global enable; 0 freezes all state.
- pc_sel, in, pc_sel_e, next-PC source.
- branch_target, in, 32, ALU branch target.
- jump_target, in, 32, jump target.
- id_ready, in, 1, decode accepts instruction.
- flush_icache, in, 1, invalidate cache.
- load_ctrl, in, 1, testbench owns the memory port.
- load_addr, in, ADDR_W, program-load word address.
- load_data, in, 32, program-load data.
- imem_csb, out, 1, SRAM chip select (active low).
- imem_web, out, 1, SRAM write enable (active low).
- imem_addr, out, ADDR_W, SRAM word address.
- imem_din, out, 32, SRAM write data.
- imem_dout, in, 32, SRAM read data (1-cycle latency).
- instr, out, 32, fetched instruction.
- instr_valid, out, 1, instr is valid this cycle.
- pc, out, 32, current PC.
- pc_link, out, 32, pc+4.
- busy, out, 1, refill in progress.

Function
REQ-003 The PC SHALL be a byte address; word index = pc[ADDR_W+1:2], offset = low log2(LINE_WORDS) bits of the index, line index = next log2(LINES) bits, tag = remaining index bits.
REQ-004 Lookup SHALL be combinational in IDLE; hit = valid[line] and tag match; on hit, instr = cached word and instr_valid = 1.
REQ-005 The PC SHALL load pc+4 at the clock edge where instr_valid and id_ready are both 1 and pc_sel = PC_NEXT.
REQ-006 pc_sel = PC_BRANCH_ALU or PC_JUMP SHALL load branch_target or jump_target respectively at the next edge, regardless of hit or id_ready; instr_valid SHALL be 0 in that cycle.
REQ-007 A miss in IDLE SHALL enter REFILL; reads for words 0..LINE_WORDS-1 of the line SHALL issue on consecutive cycles; each returned word SHALL be written one cycle later.
REQ-008 The FSM SHALL then pass through LAST, writing the final word and setting valid and tag, and return to IDLE; miss-to-instr_valid latency = LINE_WORDS+2 cycles.
REQ-009 A redirect during REFILL/LAST SHALL update the PC immediately; the refill SHALL complete for the original line; lookup SHALL resume at the new PC.
REQ-010 busy = 1 in REFILL and LAST; instr_valid = 0 whenever busy.
REQ-011 flush_icache in IDLE SHALL clear all valid bits at the next edge; during a refill it SHALL be latched pending and applied on the edge that returns to IDLE, discarding the refilled line as well.
REQ-012 load_ctrl = 1 SHALL route load_addr/load_data to the SRAM with imem_web = 0 and imem_csb = 0, hold the FSM in IDLE, force instr_valid = 0 and freeze the PC; the falling edge of load_ctrl SHALL invalidate the cache.
REQ-013 load_ctrl asserted mid-refill SHALL abort the refill without setting valid.
REQ-014 Outside load and refill, imem_csb = 1 and imem_web = 1.
REQ-015 EN = 0 SHALL freeze the PC, FSM and cache writes and force imem_csb = 1.
REQ-016 pc_link = pc + 4, with wrap modulo 2^32.

Reset
REQ-017 RSTn low SHALL asynchronously set pc = RESET_PC, state = IDLE, all valid bits = 0, flush-pending = 0, instr_valid = 0, busy = 0, imem_csb = 1, imem_web = 1.
REQ-018 Tag and data arrays need no reset.

Structure
REQ-019 pc_sel_e (PC_NEXT, PC_BRANCH_ALU, PC_JUMP) and fetch_state_e (IDLE, REFILL, LAST) SHALL live in my_pkg.
REQ-020 Tag, valid and data arrays SHALL form one sub-module, icache_dm, with a single write port and an asynchronous read port.

Verification (defaults)
REQ-021 Cold fetch: reset, program words 0..7 = 0x1000+i, id_ready = 1 -> instr_valid first at cycle 6, instr = 0x1000; then 0x1001..0x1003 on consecutive cycles.
REQ-022 Line wrap: continue fetching -> miss at pc = 0x10, 6-cycle gap, then instr = 0x1004.
REQ-023 Redirect mid-refill: PC_JUMP to 0x0 at refill cycle 2 -> refill completes; the next instr_valid shows 0x1000 with no further miss.
REQ-024 Backpressure: id_ready = 0 for 3 cycles on a hit -> pc and instr hold stable.
REQ-025 Flush during refill: flush at refill cycle 1 -> after the refill, pc re-misses; total 12 cycles to the first valid.
REQ-026 Reset mid-refill: RSTn low asynchronously -> pc = RESET_PC and busy = 0 within the same cycle.
